read_return_buffer: RTL and testbench
=====================================

READ_RETURN_BUFFER -- requirements
Module: read_return_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning read-data FIFO entries (power of two, >=4).
REQ-002 The block SHALL have parameter STALL_THRESH, default 6, meaning the occupancy+outstanding level at which the backend is stalled.
REQ-003 The block SHALL have parameter DATA_W, default `DQ_BITS*8, meaning one BL8 burst of read data.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; one clock, all logic on its rising edge.
REQ-005 The block SHALL have port power_on_rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port i_read_issue, input, 1 bit: pulse when the backend accepts a READ command (valid && ready && op_type==OP_READ).
REQ-007 The block SHALL have port i_backend_read_data, input, DATA_W bits: burst data from the backend controller.
REQ-008 The block SHALL have port i_backend_read_data_valid, input, 1 bit: burst data valid (push).
REQ-009 The block SHALL have port o_backend_controller_stall, output, 1 bit: stall to backend issue FIFO.
REQ-010 The block SHALL have port o_read_data, output, DATA_W bits: FIFO head data to frontend.
REQ-011 The block SHALL have port o_read_data_valid, output, 1 bit: FIFO head valid.
REQ-012 The block SHALL have port i_frontend_controller_ready, input, 1 bit: frontend accepts head (pop = valid && ready).
REQ-013 The block SHALL have port o_outstanding, output, $clog2(DEPTH)+1 bits: reads issued but not yet returned.
REQ-014 The block SHALL have port o_overflow_err, output, 1 bit: sticky error flag.

Function
REQ-015 The FIFO SHALL be first-word-fall-through: data pushed in cycle N appears on o_read_data with o_read_data_valid=1 in cycle N+1 when the FIFO was empty.
REQ-016 o_read_data_valid SHALL equal (count != 0); o_read_data SHALL hold the head entry and remain stable while valid && !ready.
REQ-017 A push SHALL be accepted iff count < DEPTH or a pop occurs in the same cycle.
REQ-018 Simultaneous push and pop SHALL leave count unchanged, including at count==DEPTH.
REQ-019 A push that is not accepted SHALL be dropped and SHALL set o_overflow_err, which stays 1 until reset.
REQ-020 A pop with count==0 cannot occur, since valid=0; ready SHALL be ignored when empty.
REQ-021 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0; count SHALL be $clog2(DEPTH)+1 bits.
REQ-022 The outstanding counter SHALL update as follows:
- +1 on i_read_issue
- -1 on i_backend_read_data_valid
- unchanged when both occur
- saturate at 0 and at 2*DEPTH-1
- decrement at 0 sets o_overflow_err
REQ-023 o_backend_controller_stall SHALL be registered and equal 1 in cycle N+1 iff (count + outstanding) >= STALL_THRESH, evaluated on cycle-N next-state values.
REQ-024 Stall SHALL deassert one cycle after the sum drops below STALL_THRESH; there is no hysteresis.
REQ-025 The block SHALL have no internal state machine beyond the counters; behaviour is fully determined by count, outstanding, pointers and the error flag.

Reset
REQ-026 While power_on_rst=1 at a rising edge, all of the following SHALL be 0 on the next cycle:
- pointers and count
- outstanding
- o_overflow_err
- o_backend_controller_stall
- o_read_data_valid
REQ-027 o_read_data SHALL read 0 after reset; FIFO storage need not be cleared.
REQ-028 Reset asserted mid-operation SHALL discard all buffered data and outstanding credit, and SHALL ignore push, pop and issue in that cycle.

Structure
REQ-029 DEPTH and STALL_THRESH defaults SHALL be constants in frontend_command_definition_pkg, as RD_RET_DEPTH and RD_RET_STALL_THRESH.
REQ-030 Storage and pointers SHALL be a sub-module sync_fifo (parameters WIDTH and DEPTH; push, pop, full, empty, count); credit and stall logic SHALL stay in read_return_buffer.

Verification
REQ-031 After reset, 3 pushes with ready=1 -> o_read_data_valid high cycles 2..4 after the first push, data in order, count returns to 0.
REQ-032 With ready=0, 8 pushes -> count=8; a 9th push -> dropped, o_overflow_err=1 and stays 1.
REQ-033 With count=8 and ready=1, push and pop in the same cycle -> count stays 8, new data at the tail, no error.
REQ-034 From reset, 6 i_read_issue pulses with no data returned -> o_outstanding=6 and stall=1 one cycle after the 6th; one pop with count+outstanding=5 -> stall=0 next cycle.
REQ-035 i_read_issue and i_backend_read_data_valid in the same cycle at outstanding=3 -> outstanding stays 3, count +1.
REQ-036 power_on_rst pulsed with count=5 and outstanding=2 -> next cycle valid=0, outstanding=0, stall=0, error=0.

Source files
------------

// File: rtl/frontend_command_definition_pkg.sv
// Shared constants for the frontend command path: read-return buffer sizing
// and the default DQ width used to size one BL8 read burst.

`ifndef DQ_BITS
`define DQ_BITS 8
`endif

package frontend_command_definition_pkg;

    // Read-return FIFO entries (power of two, >= 4).
    localparam int RD_RET_DEPTH        = 8;

    // Occupancy + outstanding level at which the backend issue path is stalled.
    localparam int RD_RET_STALL_THRESH = 6;

    // One BL8 burst of read data.
    localparam int RD_RET_DATA_W       = `DQ_BITS * 8;

endpackage : frontend_command_definition_pkg

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO. The head entry is presented
// combinationally, so data pushed into an empty FIFO is visible the cycle
// after the push. A push into a full FIFO is accepted only when a pop frees
// a slot in the same cycle; otherwise it is dropped (the caller flags it).

module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             push_ok;
    logic             pop_ok;

    // Accept/pop qualification and next pointer/count values.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        pop_ok   = pop && (count_q != '0);
        push_ok  = push && ((count_q != CW'(DEPTH)) || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // Power-of-two depth: pointers wrap from DEPTH-1 to 0 naturally.
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; writes are suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; contents are only observable
        // through the head mux below, which masks them while empty.
        if (push_ok && !rst) mem_q[wr_ptr_q] <= wdata;
    end

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];

endmodule : sync_fifo

// File: rtl/read_return_buffer.sv
// Read-return buffer between the backend controller and the frontend.
// Buffers returned BL8 bursts in a FWFT FIFO, tracks reads issued but not yet
// returned, and stalls the backend issue path when buffered plus in-flight
// reads would reach the configured threshold. Dropped pushes and returns with
// no outstanding read raise a sticky error.

`ifndef DQ_BITS
`define DQ_BITS 8
`endif

module read_return_buffer
    import frontend_command_definition_pkg::*;
#(
    parameter int DEPTH        = RD_RET_DEPTH,
    parameter int STALL_THRESH = RD_RET_STALL_THRESH,
    parameter int DATA_W       = `DQ_BITS * 8
) (
    input  logic                   clk,
    input  logic                   power_on_rst,
    input  logic                   i_read_issue,
    input  logic [DATA_W-1:0]      i_backend_read_data,
    input  logic                   i_backend_read_data_valid,
    output logic                   o_backend_controller_stall,
    output logic [DATA_W-1:0]      o_read_data,
    output logic                   o_read_data_valid,
    input  logic                   i_frontend_controller_ready,
    output logic [$clog2(DEPTH):0] o_outstanding,
    output logic                   o_overflow_err
);

    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int SUM_W = CW + 1;
    localparam logic [CW-1:0]    OUT_MAX  = CW'(2 * DEPTH - 1);
    localparam logic [SUM_W-1:0] THRESH_V = SUM_W'(STALL_THRESH);

    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic              pop;
    logic              push_accept;
    logic              push_drop;
    logic              underflow;
    logic [SUM_W-1:0]  count_nxt;
    logic [SUM_W-1:0]  level_nxt;

    logic [CW-1:0]     outstanding_q, outstanding_d;
    logic              overflow_err_q, overflow_err_d;
    logic              stall_q, stall_d;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (power_on_rst),
        .push  (i_backend_read_data_valid),
        .pop   (pop),
        .wdata (i_backend_read_data),
        .rdata (o_read_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign o_read_data_valid = !fifo_empty;
    assign pop               = o_read_data_valid && i_frontend_controller_ready;

    // Outstanding-read credit: +1 per issue, -1 per returned burst, saturating.
    always_comb begin
        outstanding_d = outstanding_q;
        underflow     = 1'b0;
        if (i_read_issue && !i_backend_read_data_valid) begin
            if (outstanding_q != OUT_MAX) outstanding_d = outstanding_q + CW'(1);
        end else if (i_backend_read_data_valid && !i_read_issue) begin
            if (outstanding_q == '0) underflow = 1'b1;
            else                     outstanding_d = outstanding_q - CW'(1);
        end
    end

    // Next-cycle FIFO level, error accumulation and stall decision.
    always_comb begin
        push_accept = i_backend_read_data_valid && (!fifo_full || pop);
        push_drop   = i_backend_read_data_valid && !push_accept;

        count_nxt = {1'b0, fifo_count};
        case ({push_accept, pop})
            2'b10:   count_nxt = {1'b0, fifo_count} + SUM_W'(1);
            2'b01:   count_nxt = {1'b0, fifo_count} - SUM_W'(1);
            default: count_nxt = {1'b0, fifo_count};
        endcase

        level_nxt      = count_nxt + {1'b0, outstanding_d};
        stall_d        = (level_nxt >= THRESH_V);
        overflow_err_d = overflow_err_q || push_drop || underflow;
    end

    // Credit, error and stall registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (power_on_rst) begin
            outstanding_q  <= '0;
            overflow_err_q <= 1'b0;
            stall_q        <= 1'b0;
        end else begin
            outstanding_q  <= outstanding_d;
            overflow_err_q <= overflow_err_d;
            stall_q        <= stall_d;
        end
    end

    assign o_outstanding              = outstanding_q;
    assign o_overflow_err             = overflow_err_q;
    assign o_backend_controller_stall = stall_q;

endmodule : read_return_buffer

// File: tb/tb_read_return_buffer.sv
// Self-checking bench for read_return_buffer: directed scenarios followed by
// randomized traffic, all compared against a queue-based behavioural model.

module tb_read_return_buffer;

    localparam int DEPTH   = 8;
    localparam int THRESH  = 6;
    localparam int DW      = 64;
    localparam int OUT_MAX = 2 * DEPTH - 1;

    logic            clk = 1'b0;
    logic            power_on_rst = 1'b1;
    logic            i_read_issue = 1'b0;
    logic [DW-1:0]   i_backend_read_data = '0;
    logic            i_backend_read_data_valid = 1'b0;
    logic            i_frontend_controller_ready = 1'b0;
    logic            o_backend_controller_stall;
    logic [DW-1:0]   o_read_data;
    logic            o_read_data_valid;
    logic [$clog2(DEPTH):0] o_outstanding;
    logic            o_overflow_err;

    always #5 clk = ~clk;

    read_return_buffer #(
        .DEPTH        (DEPTH),
        .STALL_THRESH (THRESH),
        .DATA_W       (DW)
    ) dut (
        .clk                         (clk),
        .power_on_rst                (power_on_rst),
        .i_read_issue                (i_read_issue),
        .i_backend_read_data         (i_backend_read_data),
        .i_backend_read_data_valid   (i_backend_read_data_valid),
        .o_backend_controller_stall  (o_backend_controller_stall),
        .o_read_data                 (o_read_data),
        .o_read_data_valid           (o_read_data_valid),
        .i_frontend_controller_ready (i_frontend_controller_ready),
        .o_outstanding               (o_outstanding),
        .o_overflow_err              (o_overflow_err)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state.
    logic [DW-1:0] m_q [$];
    int            m_out   = 0;
    bit            m_err   = 1'b0;
    bit            m_stall = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock of the reference model, straight from the block's rules.
    task automatic model_step(input bit iss, input bit push, input logic [DW-1:0] d,
                              input bit rdy, input bit rst);
        bit pop;
        bit acc;
        if (rst) begin
            m_q.delete();
            m_out   = 0;
            m_err   = 1'b0;
            m_stall = 1'b0;
            return;
        end
        pop = rdy && (m_q.size() > 0);
        acc = push && ((m_q.size() < DEPTH) || pop);
        if (push && !acc) m_err = 1'b1;
        if (pop) void'(m_q.pop_front());
        if (acc) m_q.push_back(d);
        if (iss && !push) begin
            if (m_out < OUT_MAX) m_out++;
        end else if (push && !iss) begin
            if (m_out == 0) m_err = 1'b1;
            else            m_out--;
        end
        m_stall = ((m_q.size() + m_out) >= THRESH);
    endtask

    task automatic check_outputs(input string tag);
        check($sformatf("%s_valid", tag), 64'(o_read_data_valid), 64'(m_q.size() != 0));
        if (m_q.size() != 0)
            check($sformatf("%s_data", tag), o_read_data, m_q[0]);
        check($sformatf("%s_outst", tag), 64'(o_outstanding), 64'(m_out));
        check($sformatf("%s_err", tag), 64'(o_overflow_err), 64'(m_err));
        check($sformatf("%s_stall", tag), 64'(o_backend_controller_stall), 64'(m_stall));
    endtask

    // Drive one cycle of inputs, clock, advance the model and compare.
    task automatic step(input string tag, input bit iss, input bit push,
                        input logic [DW-1:0] d, input bit rdy, input bit rst);
        power_on_rst                = rst;
        i_read_issue                = iss;
        i_backend_read_data_valid   = push;
        i_backend_read_data         = d;
        i_frontend_controller_ready = rdy;
        @(posedge clk);
        model_step(iss, push, d, rdy, rst);
        #1;
        check_outputs(tag);
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom(), $urandom()};
    endfunction

    task automatic do_reset();
        step("rst", 1'b0, 1'b0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        // Reset state.
        do_reset();
        do_reset();
        check("rst_data_zero", o_read_data, 64'd0);
        check("rst_valid_zero", 64'(o_read_data_valid), 64'd0);

        // Three pushes with the frontend always ready; FWFT ordering.
        for (int i = 0; i < 3; i++) step("fwft", 1'b1, 1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step("fwft", 1'b0, 1'b1, 64'hA0 + 64'(i), 1'b1, 1'b0);
        step("fwft", 1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("fwft_drained", 64'(o_read_data_valid), 64'd0);

        // Fill to DEPTH with ready low, then one push too many.
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) step("fill_iss", 1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) step("fill", 1'b0, 1'b1, 64'hB0 + 64'(i), 1'b0, 1'b0);
        check("fill_no_err", 64'(o_overflow_err), 64'd0);
        step("ovf", 1'b0, 1'b1, 64'hBAD, 1'b0, 1'b0);
        check("ovf_err_set", 64'(o_overflow_err), 64'd1);
        for (int i = 0; i < 3; i++) step("ovf_hold", 1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("ovf_err_sticky", 64'(o_overflow_err), 64'd1);

        // Push and pop together while full: count unchanged, no error.
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) step("full_iss", 1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) step("full", 1'b0, 1'b1, 64'hC0 + 64'(i), 1'b0, 1'b0);
        step("full_pp", 1'b0, 1'b1, 64'hCF, 1'b1, 1'b0);
        check("full_pp_no_err", 64'(o_overflow_err), 64'd0);
        check("full_pp_head", o_read_data, 64'hC1);
        for (int i = 0; i < DEPTH; i++) step("full_drain", 1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("full_drain_empty", 64'(o_read_data_valid), 64'd0);

        // Six issues reach the stall threshold; a return then a pop releases it.
        do_reset();
        for (int i = 0; i < 6; i++) step("stall_iss", 1'b1, 1'b0, '0, 1'b0, 1'b0);
        check("stall_outst6", 64'(o_outstanding), 64'd6);
        check("stall_on", 64'(o_backend_controller_stall), 64'd1);
        step("stall_ret", 1'b0, 1'b1, 64'hD0, 1'b0, 1'b0);
        check("stall_still_on", 64'(o_backend_controller_stall), 64'd1);
        step("stall_pop", 1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("stall_off", 64'(o_backend_controller_stall), 64'd0);

        // Issue and return in the same cycle leave outstanding unchanged.
        do_reset();
        for (int i = 0; i < 3; i++) step("both_iss", 1'b1, 1'b0, '0, 1'b0, 1'b0);
        step("both", 1'b1, 1'b1, 64'hE0, 1'b0, 1'b0);
        check("both_outst3", 64'(o_outstanding), 64'd3);
        check("both_valid", 64'(o_read_data_valid), 64'd1);

        // Reset mid-operation with all inputs active.
        do_reset();
        for (int i = 0; i < 7; i++) step("mid_iss", 1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step("mid_push", 1'b0, 1'b1, 64'hF0 + 64'(i), 1'b0, 1'b0);
        check("mid_outst2", 64'(o_outstanding), 64'd2);
        step("mid_rst", 1'b1, 1'b1, 64'hFF, 1'b1, 1'b1);
        check("mid_rst_valid", 64'(o_read_data_valid), 64'd0);
        check("mid_rst_outst", 64'(o_outstanding), 64'd0);
        check("mid_rst_stall", 64'(o_backend_controller_stall), 64'd0);
        check("mid_rst_err", 64'(o_overflow_err), 64'd0);
        check("mid_rst_data", o_read_data, 64'd0);

        // Randomized traffic; returns biased towards cycles with reads in flight.
        for (int i = 0; i < 3000; i++) begin
            bit iss;
            bit push;
            bit rdy;
            bit rst;
            iss  = ($urandom_range(0, 99) < 40);
            push = (m_out > 0) ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 3);
            rdy  = ($urandom_range(0, 99) < 55);
            rst  = ($urandom_range(0, 199) == 0);
            step("rand", iss, push, rnd_data(), rdy, rst);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_read_return_buffer
